// File: rtl/gate_ctrl_if.sv
// gate_ctrl control/status bundle.
// master drives requests, slave is the sequencer.
interface gate_ctrl_if;
  logic start;
  logic auto_mode;
  logic abort;
  logic msd_co;
  logic cnt_clear_n;
  logic cnt_en;
  logic latch;
  logic done;
  logic overflow;
  logic busy;

  modport master (
    output start, auto_mode, abort, msd_co,
    input  cnt_clear_n, cnt_en, latch, done,
    input  overflow, busy
  );

  modport slave (
    input  start, auto_mode, abort, msd_co,
    output cnt_clear_n, cnt_en, latch, done,
    output overflow, busy
  );
endinterface

// File: rtl/gate_ctrl.sv
// Measurement sequencer for cascaded BCD decades:
// clear, gate, settle, latch, hold; single-shot or auto.
module gate_ctrl #(
  parameter int GATE_CYCLES = 1000,
  parameter int CLR_CYCLES  = 2,
  parameter int HOLD_CYCLES = 500,
  parameter int TW          = 16
) (
  input logic        clk,
  input logic        clear_n,
  gate_ctrl_if.slave gif
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, GATE, SETTLE, LATCH, HOLD
  } state_t;

  localparam logic [TW-1:0] CLR_LAST  = TW'(CLR_CYCLES - 1);
  localparam logic [TW-1:0] GATE_LAST = TW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);

  state_t        state;
  state_t        state_nx;
  logic [TW-1:0] timer;
  logic          msd_co_d;
  logic          ovf_run;
  logic          ovf_set;
  logic          clr_n_r;
  logic          en_r;
  logic          latch_r;
  logic          busy_r;
  logic          ovf_r;

  // 9->0 wrap of the top decade while the gate result can still change
  assign ovf_set = (state == GATE || state == SETTLE)
                 && msd_co_d && !gif.msd_co;

  // State register
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state logic; abort overrides everything, including start in IDLE
  always_comb begin
    state_nx = state;
    if (gif.abort) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:
          if (gif.start || gif.auto_mode) state_nx = CLEAR;
        CLEAR:
          if (timer == CLR_LAST) state_nx = GATE;
        GATE:
          if (timer == GATE_LAST) state_nx = SETTLE;
        SETTLE:
          state_nx = LATCH;
        LATCH:
          state_nx = HOLD;
        HOLD:
          if (timer == HOLD_LAST)
            state_nx = gif.auto_mode ? CLEAR : IDLE;
        default:
          state_nx = IDLE;
      endcase
    end
  end

  // Per-state timer, restarted on every state change
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n)
      timer <= '0;
    else if (state_nx != state || state == IDLE)
      timer <= '0;
    else
      timer <= timer + 1'b1;
  end

  // Overflow tracking across the gate and settle window
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      msd_co_d <= 1'b0;
      ovf_run  <= 1'b0;
    end else begin
      msd_co_d <= gif.msd_co;
      if (state == CLEAR)
        ovf_run <= 1'b0;
      else if (ovf_set)
        ovf_run <= 1'b1;
    end
  end

  // Registered outputs decoded from the state being entered
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      clr_n_r <= 1'b0;
      en_r    <= 1'b0;
      latch_r <= 1'b0;
      busy_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      clr_n_r <= (state_nx != CLEAR);
      en_r    <= (state_nx == GATE);
      latch_r <= (state_nx == LATCH);
      busy_r  <= (state_nx != IDLE);
      if (state_nx == LATCH)
        ovf_r <= ovf_run | ovf_set;
    end
  end

  assign gif.cnt_clear_n = clr_n_r;
  assign gif.cnt_en      = en_r;
  assign gif.latch       = latch_r;
  assign gif.done        = latch_r;
  assign gif.busy        = busy_r;
  assign gif.overflow    = ovf_r;

endmodule

// File: tb/tb_gate_ctrl.sv
// Self-checking bench for gate_ctrl.
// GATE=10, CLR=2, HOLD=5; scoreboard holds expected overflow per latch.
module tb_gate_ctrl;

  localparam int MAXN = 100;

  logic clk;
  logic clear_n;
  gate_ctrl_if gif ();

  gate_ctrl #(
    .GATE_CYCLES(10),
    .CLR_CYCLES (2),
    .HOLD_CYCLES(5),
    .TW         (8)
  ) dut (
    .clk    (clk),
    .clear_n(clear_n),
    .gif    (gif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp;
  int   n_err;
  logic exp_q[$];

  logic en_a   [1:MAXN];
  logic clrn_a [1:MAXN];
  logic lat_a  [1:MAXN];
  logic done_a [1:MAXN];
  logic busy_a [1:MAXN];
  logic ovf_a  [1:MAXN];

  // Sample cycle k at negedge k, then drive inputs for cycle k.
  task automatic capture(input int n, input int st_k,
                         input int ab_from, input int ab_to,
                         input int mf, input int mt,
                         input int auto_off_k);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      en_a[k]   = gif.cnt_en;
      clrn_a[k] = gif.cnt_clear_n;
      lat_a[k]  = gif.latch;
      done_a[k] = gif.done;
      busy_a[k] = gif.busy;
      ovf_a[k]  = gif.overflow;
      gif.start  = (k == st_k);
      gif.abort  = (k >= ab_from && k <= ab_to);
      gif.msd_co = (k >= mf && k <= mt);
      if (k == auto_off_k) gif.auto_mode = 1'b0;
    end
  endtask

  task automatic test_reset();
    gif.start = 0; gif.auto_mode = 0; gif.abort = 0; gif.msd_co = 0;
    clear_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({gif.cnt_clear_n, gif.cnt_en, gif.latch, gif.done,
         gif.overflow, gif.busy} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_vals: got %b want 000000",
               {gif.cnt_clear_n, gif.cnt_en, gif.latch, gif.done,
                gif.overflow, gif.busy});
    end
    clear_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (gif.cnt_clear_n !== 1'b1 || gif.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: clr_n=%b busy=%b want 1 0",
               gif.cnt_clear_n, gif.busy);
    end
  endtask

  task automatic test_single();
    int en_cnt, first_en, clr_lo, lat_idx, done_idx, busy_cnt;
    logic e;
    gif.start = 1'b1;
    exp_q.push_back(1'b0);
    capture(24, 0, 0, 0, 0, 0, 0);
    en_cnt = 0; first_en = 0; clr_lo = 0;
    lat_idx = 0; done_idx = 0; busy_cnt = 0;
    for (int k = 1; k <= 24; k++) begin
      if (en_a[k]) begin
        en_cnt++;
        if (first_en == 0) first_en = k;
      end
      if (!clrn_a[k]) clr_lo++;
      if (lat_a[k] && lat_idx == 0) lat_idx = k;
      if (done_a[k] && done_idx == 0) done_idx = k;
      if (busy_a[k]) busy_cnt++;
      if (lat_a[k]) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL single_sb: unexpected latch at %0d", k);
        end else begin
          e = exp_q.pop_front();
          if (ovf_a[k] !== e) begin
            n_err++;
            $display("FAIL single_sb: ovf=%b want %b", ovf_a[k], e);
          end
        end
      end
    end
    n_cmp++;
    if (clr_lo != 2 || clrn_a[1] !== 1'b0 || clrn_a[2] !== 1'b0) begin
      n_err++;
      $display("FAIL single_clear: low=%0d want 2 at cycles 1-2", clr_lo);
    end
    n_cmp++;
    if (en_cnt != 10 || first_en != 3) begin
      n_err++;
      $display("FAIL single_gate: cnt=%0d first=%0d want 10 3",
               en_cnt, first_en);
    end
    n_cmp++;
    if (lat_idx != 14 || done_idx != 14) begin
      n_err++;
      $display("FAIL single_latch: latch=%0d done=%0d want 14 14",
               lat_idx, done_idx);
    end
    n_cmp++;
    if (busy_cnt != 19 || busy_a[19] !== 1'b1 || busy_a[20] !== 1'b0) begin
      n_err++;
      $display("FAIL single_busy: cnt=%0d want 19 ending at 19", busy_cnt);
    end
  endtask

  task automatic test_overflow_set();
    logic e;
    gif.start = 1'b1;
    exp_q.push_back(1'b1);
    capture(22, 0, 0, 0, 5, 6, 0);
    for (int k = 1; k <= 22; k++) begin
      if (lat_a[k]) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL ovf_set_sb: unexpected latch at %0d", k);
        end else begin
          e = exp_q.pop_front();
          if (ovf_a[k] !== e) begin
            n_err++;
            $display("FAIL ovf_set_sb: ovf=%b want %b", ovf_a[k], e);
          end
        end
      end
    end
    n_cmp++;
    if (ovf_a[13] !== 1'b0 || ovf_a[14] !== 1'b1 || ovf_a[22] !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_set: c13=%b c14=%b c22=%b want 0 1 1",
               ovf_a[13], ovf_a[14], ovf_a[22]);
    end
  endtask

  task automatic test_abort();
    int lat_cnt, done_cnt;
    gif.start = 1'b1;
    capture(22, 0, 6, 6, 0, 0, 0);
    lat_cnt = 0; done_cnt = 0;
    for (int k = 1; k <= 22; k++) begin
      if (lat_a[k]) lat_cnt++;
      if (done_a[k]) done_cnt++;
    end
    n_cmp++;
    if (en_a[6] !== 1'b1 || en_a[7] !== 1'b0 || busy_a[7] !== 1'b0) begin
      n_err++;
      $display("FAIL abort_stop: en6=%b en7=%b busy7=%b want 1 0 0",
               en_a[6], en_a[7], busy_a[7]);
    end
    n_cmp++;
    if (lat_cnt != 0 || done_cnt != 0) begin
      n_err++;
      $display("FAIL abort_nolatch: latch=%0d done=%0d want 0 0",
               lat_cnt, done_cnt);
    end
    n_cmp++;
    if (ovf_a[22] !== 1'b1 || clrn_a[7] !== 1'b1) begin
      n_err++;
      $display("FAIL abort_hold: ovf=%b clr_n=%b want 1 1",
               ovf_a[22], clrn_a[7]);
    end
  endtask

  task automatic test_overflow_clear();
    logic e;
    gif.start = 1'b1;
    exp_q.push_back(1'b0);
    capture(22, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 22; k++) begin
      if (lat_a[k]) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL ovf_clr_sb: unexpected latch at %0d", k);
        end else begin
          e = exp_q.pop_front();
          if (ovf_a[k] !== e) begin
            n_err++;
            $display("FAIL ovf_clr_sb: ovf=%b want %b", ovf_a[k], e);
          end
        end
      end
    end
    n_cmp++;
    if (ovf_a[13] !== 1'b1 || ovf_a[14] !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clear: c13=%b c14=%b want 1 0",
               ovf_a[13], ovf_a[14]);
    end
  endtask

  task automatic test_ignored_start();
    int lat_cnt, busy_cnt;
    logic e;
    gif.start = 1'b1;
    exp_q.push_back(1'b0);
    capture(30, 19, 0, 0, 0, 0, 0);
    lat_cnt = 0; busy_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      if (busy_a[k]) busy_cnt++;
      if (lat_a[k]) begin
        lat_cnt++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL ign_sb: unexpected latch at %0d", k);
        end else begin
          e = exp_q.pop_front();
          if (ovf_a[k] !== e) begin
            n_err++;
            $display("FAIL ign_sb: ovf=%b want %b", ovf_a[k], e);
          end
        end
      end
    end
    n_cmp++;
    if (lat_cnt != 1 || busy_cnt != 19 || busy_a[30] !== 1'b0) begin
      n_err++;
      $display("FAIL ign_start: latches=%0d busy=%0d want 1 19",
               lat_cnt, busy_cnt);
    end
  endtask

  task automatic test_priority();
    int busy_cnt;
    gif.start = 1'b1;
    gif.abort = 1'b1;
    capture(6, 0, 0, 0, 0, 0, 0);
    busy_cnt = 0;
    for (int k = 1; k <= 6; k++) if (busy_a[k] || !clrn_a[k]) busy_cnt++;
    n_cmp++;
    if (busy_cnt != 0) begin
      n_err++;
      $display("FAIL prio_start_abort: active=%0d want 0", busy_cnt);
    end
    gif.auto_mode = 1'b1;
    gif.abort = 1'b1;
    capture(6, 0, 1, 6, 0, 0, 6);
    gif.abort = 1'b0;
    busy_cnt = 0;
    for (int k = 1; k <= 6; k++) if (busy_a[k] || !clrn_a[k]) busy_cnt++;
    n_cmp++;
    if (busy_cnt != 0) begin
      n_err++;
      $display("FAIL prio_auto_abort: active=%0d want 0", busy_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int lat_idx[$];
    int bad_en;
    logic e;
    logic want;
    clear_n = 1'b0;
    gif.auto_mode = 1'b1;
    @(negedge clk);
    clear_n = 1'b1;
    repeat (4) exp_q.push_back(1'b0);
    capture(80, 0, 0, 0, 0, 0, 60);
    bad_en = 0;
    for (int k = 1; k <= 80; k++) begin
      want = (k >= 3 && k <= 70 && ((k - 3) % 19) < 10);
      if (en_a[k] !== want) bad_en++;
      if (lat_a[k]) begin
        lat_idx.push_back(k);
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL auto_sb: unexpected latch at %0d", k);
        end else begin
          e = exp_q.pop_front();
          if (ovf_a[k] !== e) begin
            n_err++;
            $display("FAIL auto_sb: ovf=%b want %b", ovf_a[k], e);
          end
        end
      end
    end
    n_cmp++;
    if (lat_idx.size() != 4) begin
      n_err++;
      $display("FAIL auto_count: latches=%0d want 4", lat_idx.size());
    end else begin
      if (lat_idx[0] != 14) begin
        n_err++;
        $display("FAIL auto_first: latch=%0d want 14", lat_idx[0]);
      end
      for (int i = 1; i < 4; i++) begin
        n_cmp++;
        if (lat_idx[i] - lat_idx[i-1] != 19) begin
          n_err++;
          $display("FAIL auto_period: gap=%0d want 19",
                   lat_idx[i] - lat_idx[i-1]);
        end
      end
    end
    n_cmp++;
    if (bad_en != 0) begin
      n_err++;
      $display("FAIL auto_gate: %0d cnt_en cycles wrong, want 0", bad_en);
    end
    n_cmp++;
    if (busy_a[76] !== 1'b1 || busy_a[77] !== 1'b0) begin
      n_err++;
      $display("FAIL auto_stop: busy76=%b busy77=%b want 1 0",
               busy_a[76], busy_a[77]);
    end
  endtask

  task automatic test_async_reset();
    gif.start = 1'b1;
    capture(6, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (en_a[6] !== 1'b1) begin
      n_err++;
      $display("FAIL arst_pre: en=%b want 1", en_a[6]);
    end
    #2;
    clear_n = 1'b0;
    #1;
    n_cmp++;
    if (gif.cnt_en !== 1'b0 || gif.cnt_clear_n !== 1'b0 ||
        gif.busy !== 1'b0 || gif.overflow !== 1'b0) begin
      n_err++;
      $display("FAIL arst_now: en=%b clr_n=%b busy=%b ovf=%b want 0 0 0 0",
               gif.cnt_en, gif.cnt_clear_n, gif.busy, gif.overflow);
    end
    @(negedge clk);
    clear_n = 1'b1;
    #1;
    n_cmp++;
    if (gif.cnt_clear_n !== 1'b0) begin
      n_err++;
      $display("FAIL arst_hold: clr_n=%b want 0", gif.cnt_clear_n);
    end
    @(negedge clk);
    n_cmp++;
    if (gif.cnt_clear_n !== 1'b1 || gif.latch !== 1'b0 ||
        gif.busy !== 1'b0) begin
      n_err++;
      $display("FAIL arst_release: clr_n=%b latch=%b busy=%b want 1 0 0",
               gif.cnt_clear_n, gif.latch, gif.busy);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_overflow_set();
    test_abort();
    test_overflow_clear();
    test_ignored_start();
    test_priority();
    test_back_to_back();
    test_async_reset();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d expected latches never seen, want 0",
               exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
